// File: rtl/jelly_stream_packet_arbiter_pkg.sv
// Shared constants for the packet arbiter: FSM encoding and id width helper.
package jelly_stream_packet_arbiter_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  function automatic int id_bits(input int id_width);
    return (id_width > 1) ? id_width : 1;
  endfunction

endpackage

// File: rtl/jelly_rr_priority_select.sv
// Round-robin pick: first requester after prev, wrapping modulo NUM.
module jelly_rr_priority_select #(
  parameter int NUM     = 8,
  parameter int ID_BITS = 3
) (
  input  logic [NUM-1:0]     req,
  input  logic [ID_BITS-1:0] prev,
  output logic [ID_BITS-1:0] sel,
  output logic               any
);

  // Scan from the farthest slot back to prev+1 so the nearest request wins.
  always_comb begin
    sel = '0;
    any = |req;
    for (int k = NUM; k >= 1; k--) begin
      int idx;
      idx = (int'(prev) + k) % NUM;
      if (req[idx]) sel = ID_BITS'(idx);
    end
  end

endmodule

// File: rtl/jelly_stream_packet_arbiter.sv
// Packet-granular round-robin stream arbiter with registered output slot.
// Optional per-grant beat limit: JELLY_STREAM_PACKET_ARBITER_LEN_LIMIT_EN.
module jelly_stream_packet_arbiter
  import jelly_stream_packet_arbiter_pkg::*;
#(
  parameter int NUM        = 8,
  parameter int ID_WIDTH   = 3,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int MAX_LEN    = 16
) (
  input  logic                          reset,
  input  logic                          clk,
  input  logic                          cke,
  input  logic [NUM-1:0]                s_last,
  input  logic [NUM*DATA_WIDTH-1:0]     s_data,
  input  logic [NUM-1:0]                s_valid,
  output logic [NUM-1:0]                s_ready,
  output logic [id_bits(ID_WIDTH)-1:0]  m_id,
  output logic                          m_last,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_valid,
  input  logic                          m_ready
);

  localparam int ID_BITS = id_bits(ID_WIDTH);

  if (MAX_LEN < 1 || MAX_LEN > (1 << LEN_WIDTH)) begin : g_len_check
    $error("MAX_LEN must be in 1..2**LEN_WIDTH");
  end

  logic                               state, state_next;
  logic [ID_BITS-1:0]                 grant, prev, sel;
  logic                               any, acc, last_eff;
  logic [NUM-1:0][DATA_WIDTH-1:0]     s_data_v;

  assign s_data_v = s_data;

  jelly_rr_priority_select #(.NUM(NUM), .ID_BITS(ID_BITS)) u_sel (
    .req  (s_valid),
    .prev (prev),
    .sel  (sel),
    .any  (any)
  );

  assign acc = s_valid[grant] & s_ready[grant];

`ifdef JELLY_STREAM_PACKET_ARBITER_LEN_LIMIT_EN
  logic [LEN_WIDTH-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              cnt <= '0;
    else if (cke && state == ST_IDLE && any) cnt <= '0;
    else if (acc)                           cnt <= cnt + 1'b1;
  end

  // Beat limit truncates the burst; remaining beats re-compete later.
  assign last_eff = s_last[grant] | (cnt == LEN_WIDTH'(MAX_LEN - 1));
`else
  assign last_eff = s_last[grant];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (cke && any)       state_next = ST_BUSY;
      ST_BUSY: if (acc && last_eff)  state_next = ST_IDLE;
      default:                       state_next = ST_IDLE;
    endcase
  end

  // Ready depends only on registered state and m_ready, never on s_valid.
  always_comb begin
    s_ready = '0;
    if (state == ST_BUSY && cke && (!m_valid || m_ready)) s_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant <= '0;
      prev  <= ID_BITS'(NUM - 1);
    end else if (cke && state == ST_IDLE && any) begin
      grant <= sel;
      prev  <= sel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
      m_id    <= '0;
    end else if (cke) begin
      if (acc) begin
        m_valid <= 1'b1;
        m_last  <= last_eff;
        m_data  <= s_data_v[grant];
        m_id    <= grant;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/jelly_stream_packet_arbiter.md
# jelly_stream_packet_arbiter

Packet-granular round-robin arbiter that merges NUM upstream AXI4-Stream-style channels onto one registered output stream. Once a requester is granted, it keeps the grant for a whole packet, up to and including its `last` beat. It is the arbitration stage placed per master port of the stream crossbar, after the per-slave switches. `m_id` reports which requester the current beat came from.

## Interface
Parameters:
- NUM, 8: number of requesters.
- ID_WIDTH, 3: width of `m_id`; ID_BITS = max(ID_WIDTH,1).
- DATA_WIDTH, 32: beat payload width.
- LEN_WIDTH, 8: width of the per-grant beat counter.
- MAX_LEN, 16: beat limit per grant (length-limit build only); 1 ≤ MAX_LEN ≤ 2^LEN_WIDTH.

Ports (one clock; reset is asynchronous and active-high):
- reset  in  1  asynchronous, active-high reset.
- clk  in  1  clock; all state on rising edge.
- cke  in  1  clock enable; when low, all state holds and `s_ready` = 0.
- s_last  in  NUM  per-requester last-beat flag.
- s_data  in  NUM*DATA_WIDTH  per-requester payload; requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- s_valid  in  NUM  per-requester valid.
- s_ready  out  NUM  per-requester ready; at most one bit high.
- m_id  out  ID_BITS  index of the source requester.
- m_last  out  1  output last flag.
- m_data  out  DATA_WIDTH  output payload.
- m_valid  out  1  output valid.
- m_ready  in  1  output ready.

## Operation
- FSM states: IDLE, BUSY. Registers: `grant` (ID_BITS), `prev` (last granted index), `cnt` (LEN_WIDTH), output register slot.
- IDLE, any `s_valid` high: pick the first valid index scanning prev+1, prev+2, … with wrap modulo NUM. Load `grant` and `prev` with it, clear `cnt`, go to BUSY. With no valid input, stay in IDLE.
- BUSY:
  - `s_ready[grant]` = cke & (!m_valid | m_ready). Every other `s_ready` bit is 0.
  - A beat is accepted when `s_valid[grant]` & `s_ready[grant]`. On acceptance, the output register loads data, last, and id = grant; `m_valid` is set and `cnt` increments.
  - When an accepted beat has `s_last`, the FSM returns to IDLE on the same edge.
- Output slot: if `m_valid` & `m_ready` and no new beat is loaded, `m_valid` clears on that edge.
- Simultaneous events: output drain and a new-beat load in the same cycle → the load wins, and `m_valid` stays 1.
- Only the granted requester's `s_valid` is observed in BUSY. The others wait, with no starvation: every valid requester is granted within NUM packets.
- `s_valid` dropping mid-packet does not release the grant. The FSM waits in BUSY.
- Reset values: `m_valid` = 0, `m_last` = 0, `m_data` = 0, `m_id` = 0, `s_ready` = 0, state = IDLE, `prev` = NUM-1 (first grant favours requester 0), `cnt` = 0.
- Reset asserted mid-packet aborts the grant and clears the output slot. The remaining beats of that packet are arbitrated later as a new packet.

## Timing
- Arbitration costs one cycle, with no combinational path from `s_valid` to `s_ready`.
- Latency from idle: `s_valid` at cycle 0 → grant at edge 1 → beat accepted at edge 2 (`s_ready` high during cycle 1) → `m_valid` = 1 during cycle 2.
- Throughput inside a packet: 1 beat/cycle while `m_ready` = 1.
- One bubble cycle between consecutive packets (the IDLE re-arbitration).
- `m_*` signals are purely registered.

## Configuration
- Macro JELLY_STREAM_PACKET_ARBITER_LEN_LIMIT_EN.
- Defined:
  - When `cnt` reaches MAX_LEN-1, the accepted beat is output with `m_last` forced to 1 and the grant is released to IDLE.
  - The rest of the packet re-competes as a new burst, which bounds worst-case latency for the other requesters.
- Undefined:
  - `cnt` is not built, and MAX_LEN and LEN_WIDTH are ignored.
  - The grant is released only on `s_last`.

## Structure
- Package jelly_stream_packet_arbiter_pkg holds:
  - the state encoding constants ST_IDLE = 1'b0 and ST_BUSY = 1'b1;
  - a function computing ID_BITS.
- Sub-module jelly_rr_priority_select (combinational):
  - inputs: request vector, `prev` index;
  - outputs: next grant index and an any-request flag.

## Test plan
- Single requester: requester 2 sends a 4-beat packet with data 0xA0–0xA3, `m_ready` = 1 → `m_id` = 2, data in order, `m_last` only on 0xA3, first `m_valid` two cycles after first `s_valid`.
- Round-robin: all 8 requesters hold 1-beat packets continuously → `m_id` sequence 0,1,…,7,0, with one bubble between packets.
- Backpressure: `m_ready` toggles 1,0,0,1 during a 3-beat packet → no beat lost or duplicated; `s_ready` low whenever the slot is full and `m_ready` = 0.
- Grant lock: requester 1 mid-packet while requester 0 asserts valid → no beat from requester 0 until requester 1's last beat is accepted.
- Length limit (macro defined, MAX_LEN = 4): 10-beat packet from requester 3 → output bursts of 4, 4, 2 beats, each with `m_last`; a waiting requester 5 is served between bursts.
- Reset mid-packet: assert reset after beat 2 of 5 → outputs zero immediately; after release, the remaining beats re-arbitrate starting from requester 0's priority.
